// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port register file.
//   XLEN_DEF / NREG_DEF : default data width and register count
//   wr_src_e            : which source commits the single write of a cycle
//   addr_ok()           : true when an address maps to a real, writable/readable register
package regfile_pkg;

   localparam int unsigned XLEN_DEF = 32;
   localparam int unsigned NREG_DEF = 32;

   typedef enum logic [1:0] {
      SRC_NONE,
      SRC_CORE,
      SRC_UART
   } wr_src_e;

   // Address 0 is excluded when it is hardwired to zero; out-of-range addresses are excluded.
   function automatic logic addr_ok(logic [31:0] addr, int unsigned nreg, bit zero_reg);
      return (addr < nreg) && !(zero_reg && (addr == 32'd0));
   endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle of the register file: read ports, core write channel, UART loader channel.
//   master : drives addresses, write requests and UART data; sees rd_data and uart_ready
//   slave  : the register file side
interface regfile_mp_if
   import regfile_pkg::*;
#(
   parameter int unsigned XLEN = XLEN_DEF,
   parameter int unsigned NREG = NREG_DEF,
   parameter int unsigned NRD  = 2
);
   localparam int unsigned AW = (NREG > 1) ? $clog2(NREG) : 1;

   logic [NRD*AW-1:0]   rd_addr;
   logic [NRD*XLEN-1:0] rd_data;
   logic                wr_en;
   logic                wr_tag;
   logic [AW-1:0]       wr_addr;
   logic [XLEN-1:0]     wr_data;
   logic                uart_valid;
   logic                uart_ready;
   logic [AW-1:0]       uart_addr;
   logic [XLEN-1:0]     uart_data;

   modport master (
      output rd_addr, wr_en, wr_tag, wr_addr, wr_data, uart_valid, uart_addr, uart_data,
      input  rd_data, uart_ready
   );

   modport slave (
      input  rd_addr, wr_en, wr_tag, wr_addr, wr_data, uart_valid, uart_addr, uart_data,
      output rd_data, uart_ready
   );

endinterface

// File: rtl/regfile_uart_buf.sv
// One-entry holding buffer for UART loader writes.
//   uart_valid_i/uart_ready_o : capture handshake (ready = buffer empty)
//   uart_addr_i/uart_data_i   : captured payload
//   release_i                 : entry leaves (drained or discarded) this cycle
//   valid_o/addr_o/data_o     : current buffer contents
// Capture only happens when empty and release only when full, so both never occur together
// and ready reappears the cycle after a release.
module regfile_uart_buf
   import regfile_pkg::*;
#(
   parameter int unsigned XLEN = XLEN_DEF,
   parameter int unsigned AW   = 5
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            uart_valid_i,
   output logic            uart_ready_o,
   input  logic [AW-1:0]   uart_addr_i,
   input  logic [XLEN-1:0] uart_data_i,
   input  logic            release_i,
   output logic            valid_o,
   output logic [AW-1:0]   addr_o,
   output logic [XLEN-1:0] data_o
);

   logic            valid_q, valid_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [XLEN-1:0] data_q, data_d;

   always_comb begin
      valid_d = valid_q;
      addr_d  = addr_q;
      data_d  = data_q;
      if (valid_q) begin
         if (release_i) valid_d = 1'b0;
      end else if (uart_valid_i) begin
         valid_d = 1'b1;
         addr_d  = uart_addr_i;
         data_d  = uart_data_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   assign uart_ready_o = ~valid_q;
   assign valid_o      = valid_q;
   assign addr_o       = addr_q;
   assign data_o       = data_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with a tag-deduplicated core write port and a buffered
// UART loader write port. Core writes have strict priority; one register write per cycle.
//   CLK, reset_n : rising-edge clock, asynchronous active-low reset
//   bus (slave)  : rd_addr/rd_data (1-cycle registered reads), wr_* core channel,
//                  uart_* loader channel
// Optional build macro REGFILE_BYPASS_EN: forwards the committing write data to a read port
// reading the same address in the same cycle; otherwise reads return the pre-write value.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int unsigned XLEN     = XLEN_DEF,
   parameter int unsigned NREG     = NREG_DEF,
   parameter int unsigned NRD      = 2,
   parameter bit          ZERO_REG = 1'b1
) (
   input  logic          CLK,
   input  logic          reset_n,
   regfile_mp_if.slave   bus
);

   localparam int unsigned AW = (NREG > 1) ? $clog2(NREG) : 1;

   logic [XLEN-1:0]     regs_q [NREG];
   logic [NRD*XLEN-1:0] rd_data_q, rd_data_d;
   logic                last_tag_q;

   logic                core_acc;
   logic                buf_valid;
   logic [AW-1:0]       buf_addr;
   logic [XLEN-1:0]     buf_data;
   logic                buf_release;

   wr_src_e             src;
   logic [AW-1:0]       wa;
   logic [XLEN-1:0]     wd;
   logic                we;

   // A repeated tag is a replay of the previous request and is ignored.
   assign core_acc    = bus.wr_en && (bus.wr_tag != last_tag_q);
   // Drain when the core leaves the cycle free; discard when the core overwrites the entry.
   assign buf_release = buf_valid && (!core_acc || (bus.wr_addr == buf_addr));

   regfile_uart_buf #(
      .XLEN (XLEN),
      .AW   (AW)
   ) u_uart_buf (
      .clk_i        (CLK),
      .rst_ni       (reset_n),
      .uart_valid_i (bus.uart_valid),
      .uart_ready_o (bus.uart_ready),
      .uart_addr_i  (bus.uart_addr),
      .uart_data_i  (bus.uart_data),
      .release_i    (buf_release),
      .valid_o      (buf_valid),
      .addr_o       (buf_addr),
      .data_o       (buf_data)
   );

   always_comb begin
      src = SRC_NONE;
      wa  = '0;
      wd  = '0;
      if (core_acc) begin
         src = SRC_CORE;
         wa  = bus.wr_addr;
         wd  = bus.wr_data;
      end else if (buf_valid) begin
         src = SRC_UART;
         wa  = buf_addr;
         wd  = buf_data;
      end
      we = (src != SRC_NONE) && addr_ok(32'(wa), NREG, ZERO_REG);
   end

   always_comb begin
      rd_data_d = '0;
      for (int k = 0; k < NRD; k++) begin
         if (addr_ok(32'(bus.rd_addr[k*AW +: AW]), NREG, ZERO_REG)) begin
            rd_data_d[k*XLEN +: XLEN] = regs_q[bus.rd_addr[k*AW +: AW]];
         end
`ifdef REGFILE_BYPASS_EN
         // we already excludes the hardwired zero register
         if (we && (bus.rd_addr[k*AW +: AW] == wa)) begin
            rd_data_d[k*XLEN +: XLEN] = wd;
         end
`endif
      end
   end

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
         rd_data_q  <= '0;
         last_tag_q <= 1'b1;
      end else begin
         if (we) regs_q[wa] <= wd;
         rd_data_q <= rd_data_d;
         // Dropped writes (zero/out-of-range address) still consume their tag.
         if (core_acc) last_tag_q <= bus.wr_tag;
      end
   end

   assign bus.rd_data = rd_data_q;

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   regfile_mp_if #(.XLEN(32), .NREG(32), .NRD(2)) bus ();

   regfile_mp #(
      .XLEN     (32),
      .NREG     (32),
      .NRD      (2),
      .ZERO_REG (1'b1)
   ) dut (
      .CLK     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

`ifdef REGFILE_BYPASS_EN
   localparam logic [31:0] SAME_CYC_4 = 32'h55;
`else
   localparam logic [31:0] SAME_CYC_4 = 32'h0;
`endif

   typedef struct {
      logic        we;
      logic        tag;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        uv;
      logic [4:0]  ua;
      logic [31:0] ud;
      logic [4:0]  ra0;
      logic [4:0]  ra1;
      logic        rdy;
      logic [31:0] e0;
      logic [31:0] e1;
   } vec_t;

   typedef struct {
      int          id;
      logic [31:0] e0;
      logic [31:0] e1;
   } exp_t;

   vec_t vecs[$];
   vec_t post[$];
   exp_t sbq[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   function automatic vec_t mk(logic we, logic tag, logic [4:0] wa, logic [31:0] wd,
                               logic uv, logic [4:0] ua, logic [31:0] ud,
                               logic [4:0] ra0, logic [4:0] ra1, logic rdy,
                               logic [31:0] e0, logic [31:0] e1);
      vec_t v;
      v.we = we; v.tag = tag; v.wa = wa; v.wd = wd;
      v.uv = uv; v.ua = ua; v.ud = ud;
      v.ra0 = ra0; v.ra1 = ra1; v.rdy = rdy; v.e0 = e0; v.e1 = e1;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Drive one cycle at the falling edge, queue the expected read data, compare after the edge.
   task automatic step(input vec_t v, input int id);
      exp_t e;
      @(negedge clk);
      check($sformatf("v%0d_ready", id), {31'b0, bus.uart_ready}, {31'b0, v.rdy});
      bus.wr_en      = v.we;
      bus.wr_tag     = v.tag;
      bus.wr_addr    = v.wa;
      bus.wr_data    = v.wd;
      bus.uart_valid = v.uv;
      bus.uart_addr  = v.ua;
      bus.uart_data  = v.ud;
      bus.rd_addr    = {v.ra1, v.ra0};
      sbq.push_back('{id: id, e0: v.e0, e1: v.e1});
      @(posedge clk);
      #1;
      if (sbq.size() == 0) begin
         check("scoreboard_empty", 32'd0, 32'd1);
      end else begin
         e = sbq.pop_front();
         check($sformatf("v%0d_rd0", e.id), bus.rd_data[31:0], e.e0);
         check($sformatf("v%0d_rd1", e.id), bus.rd_data[63:32], e.e1);
      end
   endtask

   task automatic idle_inputs();
      bus.wr_en = 1'b0; bus.wr_tag = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
      bus.uart_valid = 1'b0; bus.uart_addr = '0; bus.uart_data = '0;
   endtask

   initial begin
      //              we tag wa  wd            uv ua  ud      ra0 ra1 rdy e0            e1
      vecs.push_back(mk(1, 0, 5, 32'hDEADBEEF, 0, 0, 0,      1,  2,  1, 0,            0));
      vecs.push_back(mk(0, 0, 0, 0,            0, 0, 0,      5,  0,  1, 32'hDEADBEEF, 0));
      vecs.push_back(mk(1, 0, 5, 32'h1,        0, 0, 0,      5,  5,  1, 32'hDEADBEEF, 32'hDEADBEEF));
      vecs.push_back(mk(0, 0, 0, 0,            0, 0, 0,      5,  3,  1, 32'hDEADBEEF, 0));
      vecs.push_back(mk(1, 1, 5, 32'h1,        0, 0, 0,      6,  6,  1, 0,            0));
      vecs.push_back(mk(0, 0, 0, 0,            0, 0, 0,      5,  5,  1, 32'h1,        32'h1));
      vecs.push_back(mk(1, 0, 3, 32'h30,       1, 7, 32'hAA, 7,  5,  1, 0,            32'h1));
      vecs.push_back(mk(1, 1, 3, 32'h31,       0, 0, 0,      7,  5,  0, 0,            32'h1));
      vecs.push_back(mk(1, 0, 3, 32'h32,       0, 0, 0,      7,  1,  0, 0,            0));
      vecs.push_back(mk(0, 0, 0, 0,            0, 0, 0,      3,  4,  0, 32'h32,       0));
      vecs.push_back(mk(0, 0, 0, 0,            0, 0, 0,      7,  3,  1, 32'hAA,       32'h32));
      vecs.push_back(mk(0, 0, 0, 0,            1, 9, 32'h11, 9,  9,  1, 0,            0));
      vecs.push_back(mk(1, 1, 9, 32'h22,       0, 0, 0,      7,  0,  0, 32'hAA,       0));
      vecs.push_back(mk(0, 0, 0, 0,            0, 0, 0,      9,  9,  1, 32'h22,       32'h22));
      vecs.push_back(mk(0, 0, 0, 0,            0, 0, 0,      9,  2,  1, 32'h22,       0));
      vecs.push_back(mk(1, 0, 0, 32'hFF,       0, 0, 0,      0,  5,  1, 0,            32'h1));
      vecs.push_back(mk(1, 1, 2, 32'h2A,       0, 0, 0,      0,  9,  1, 0,            32'h22));
      vecs.push_back(mk(0, 0, 0, 0,            0, 0, 0,      2,  0,  1, 32'h2A,       0));
      vecs.push_back(mk(1, 0, 4, 32'h55,       0, 0, 0,      4,  4,  1, SAME_CYC_4,   SAME_CYC_4));
      vecs.push_back(mk(0, 0, 0, 0,            0, 0, 0,      4,  4,  1, 32'h55,       32'h55));
      vecs.push_back(mk(0, 0, 0, 0,            1, 0, 32'h77, 4,  0,  1, 32'h55,       0));
      vecs.push_back(mk(0, 0, 0, 0,            0, 0, 0,      0,  7,  0, 0,            32'hAA));
      vecs.push_back(mk(0, 0, 0, 0,            0, 0, 0,      0,  0,  1, 0,            0));

      // After the mid-operation reset: buffer gone, regs cleared, last_tag back to 1.
      post.push_back(mk(0, 0, 0, 0,            0, 0, 0,      10, 3,  1, 0,            0));
      post.push_back(mk(0, 0, 0, 0,            0, 0, 0,      10, 5,  1, 0,            0));
      post.push_back(mk(1, 1, 6, 32'h66,       0, 0, 0,      6,  10, 1, 0,            0));
      post.push_back(mk(0, 0, 0, 0,            0, 0, 0,      6,  6,  1, 0,            0));
      post.push_back(mk(1, 0, 6, 32'h67,       0, 0, 0,      10, 1,  1, 0,            0));
      post.push_back(mk(0, 0, 0, 0,            0, 0, 0,      6,  10, 1, 32'h67,       0));

      idle_inputs();
      bus.rd_addr = '0;
      repeat (2) @(negedge clk);
      check("reset_rd_data", bus.rd_data[31:0], 32'd0);
      check("reset_rd_data_hi", bus.rd_data[63:32], 32'd0);
      check("reset_ready", {31'b0, bus.uart_ready}, 32'd1);
      reset_n = 1'b1;

      foreach (vecs[i]) step(vecs[i], i);

      // Fill the buffer while the core keeps it from draining, then reset mid-operation.
      @(negedge clk);
      bus.uart_valid = 1'b1; bus.uart_addr = 5'd10; bus.uart_data = 32'hBB;
      bus.wr_en = 1'b1; bus.wr_tag = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = 32'h99;
      bus.rd_addr = {5'd5, 5'd4};
      @(negedge clk);
      check("mid_ready_busy", {31'b0, bus.uart_ready}, 32'd0);
      check("mid_rd_reg4", bus.rd_data[31:0], 32'h55);
      bus.uart_valid = 1'b0;
      bus.wr_tag = 1'b0; bus.wr_data = 32'h98;
      @(negedge clk);
      idle_inputs();
      reset_n = 1'b0;
      #1;
      check("rst_ready", {31'b0, bus.uart_ready}, 32'd1);
      check("rst_rd_data", bus.rd_data[31:0], 32'd0);
      check("rst_rd_data_hi", bus.rd_data[63:32], 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      foreach (post[i]) step(post[i], 100 + i);

      check("scoreboard_drained", 32'(sbq.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
